// File: rtl/tx_frame_feeder.sv
// Transmit frame feeder: host fills a byte buffer, then the TX side pulls
// one byte per request/acknowledge toggle until the frame length is reached.
module tx_frame_feeder #(
  parameter int ADDR_W = 7,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              start,
  input  logic              abort,
  input  logic              req_toggle,
  output logic [7:0]        byte_data,
  output logic              byte_last,
  output logic              ack_toggle,
  output logic              busy,
  output logic              frame_done,
  output logic              req_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [7:0]        mem [DEPTH];
  logic [7:0]        rd_q;
  logic              rd_en;

  logic [2:0]        state_q, state_d;
  logic              req_seen_q, req_seen_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [7:0]        data_q, data_d;
  logic              last_q, last_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              req_edge;
  logic              last_hit;

  assign req_edge = req_toggle != req_seen_q;
  assign last_hit = {1'b0, idx_q} == (len_q - LEN_W'(1));

  // Buffer is only writable while no frame is being served.
  always_ff @(posedge clk) begin
    if (wr_en && state_q == S_IDLE)
      mem[wr_addr] <= wr_data;
    if (rd_en)
      rd_q <= mem[idx_q];
  end

  always_comb begin
    state_d    = state_q;
    req_seen_d = req_seen_q;
    idx_d      = idx_q;
    len_d      = len_q;
    data_d     = data_q;
    last_d     = last_q;
    ack_d      = ack_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rd_en      = 1'b0;
    if (abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      busy_d     = 1'b0;
      req_seen_d = req_toggle;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && frame_len != '0) begin
            len_d   = (frame_len > DEPTH_L) ? DEPTH_L : frame_len;
            idx_d   = '0;
            busy_d  = 1'b1;
            last_d  = 1'b0;
            state_d = S_WAIT;
          end
          if (req_edge) begin
            req_seen_d = req_toggle;
            err_d      = 1'b1;
          end
        end
        S_WAIT: begin
          if (req_edge) begin
            req_seen_d = req_toggle;
            rd_en      = 1'b1;
            state_d    = S_FETCH;
          end
        end
        S_FETCH: state_d = S_PRESENT;
        S_PRESENT: begin
          data_d  = rd_q;
          last_d  = last_hit;
          ack_d   = ~ack_q;
          idx_d   = idx_q + 1'b1;
          state_d = last_hit ? S_DONE : S_WAIT;
        end
        S_DONE: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
          if (req_edge) begin
            req_seen_d = req_toggle;
            err_d      = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_seen_q <= 1'b0;
      idx_q      <= '0;
      len_q      <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_seen_q <= req_seen_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      data_q     <= data_d;
      last_q     <= last_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign byte_data  = data_q;
  assign byte_last  = last_q;
  assign ack_toggle = ack_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign req_err    = err_q;

endmodule

// File: tb/tb_tx_frame_feeder.sv
// Directed bench for tx_frame_feeder: frame service, latency, clamping,
// abort, idle requests and asynchronous reset.
module tb_tx_frame_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] frame_len;
  logic       start;
  logic       abort;
  logic       req_toggle;
  logic [7:0] byte_data;
  logic       byte_last;
  logic       ack_toggle;
  logic       busy;
  logic       frame_done;
  logic       req_err;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  always #5 clk = ~clk;

  tx_frame_feeder dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_len(frame_len), .start(start), .abort(abort),
    .req_toggle(req_toggle),
    .byte_data(byte_data), .byte_last(byte_last),
    .ack_toggle(ack_toggle), .busy(busy),
    .frame_done(frame_done), .req_err(req_err)
  );

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (req_err === 1'b1) err_cnt++;
  end

  task automatic write_byte(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] len);
    @(negedge clk);
    start = 1'b1; frame_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Toggles the request and counts posedges until the ack flips (-1 on timeout).
  task automatic req_and_wait(output logic [7:0] d, output logic l,
                              output int cyc);
    logic prev;
    @(negedge clk);
    prev = ack_toggle;
    req_toggle = ~req_toggle;
    cyc = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (ack_toggle !== prev) begin
        cyc = i;
        break;
      end
    end
    d = byte_data;
    l = byte_last;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({byte_data, byte_last, ack_toggle, busy, frame_done, req_err} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 0",
               {byte_data, byte_last, ack_toggle, busy, frame_done, req_err});
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic_frame;
    logic [7:0] exp_d [4];
    logic [7:0] d;
    logic l, a0;
    int cyc, d0;
    exp_d = '{8'h55, 8'hD5, 8'hA1, 8'h02};
    for (int i = 0; i < 4; i++) write_byte(7'(i), exp_d[i]);
    d0 = done_cnt;
    pulse_start(8'd4);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy_on got %b want 1", busy);
    end
    for (int i = 0; i < 4; i++) begin
      req_and_wait(d, l, cyc);
      n_tests++;
      if (d !== exp_d[i] || l !== (i == 3) || cyc != 3) begin
        n_fail++;
        $display("FAIL basic_byte%0d got d=%h last=%b lat=%0d want d=%h last=%b lat=3",
                 i, d, l, cyc, exp_d[i], (i == 3));
      end
      if (i == 0) begin
        a0 = ack_toggle;
        repeat (6) @(negedge clk);
        n_tests++;
        if (ack_toggle !== a0 || byte_data !== 8'h55) begin
          n_fail++;
          $display("FAIL basic_no_extra_ack got ack=%b d=%h want ack=%b d=55",
                   ack_toggle, byte_data, a0);
        end
      end
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done got pulses=%0d busy=%b want 1 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_zero_len_idle_req;
    logic a0;
    int e0;
    a0 = ack_toggle;
    pulse_start(8'd0);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_len_busy got %b want 0", busy);
    end
    e0 = err_cnt;
    @(negedge clk);
    req_toggle = ~req_toggle;
    repeat (6) @(negedge clk);
    n_tests++;
    if (err_cnt - e0 != 1 || ack_toggle !== a0) begin
      n_fail++;
      $display("FAIL idle_req_err got errs=%0d ack=%b want 1 %b",
               err_cnt - e0, ack_toggle, a0);
    end
  endtask

  task automatic run_full(input logic [7:0] len, input string tag);
    logic [7:0] d;
    logic l;
    int cyc, d0, e0, bad;
    logic a0;
    d0 = done_cnt;
    bad = 0;
    pulse_start(len);
    for (int i = 0; i < 128; i++) begin
      req_and_wait(d, l, cyc);
      if (d !== (8'(i) ^ 8'h3C) || l !== (i == 127) || cyc != 3) begin
        if (bad < 4)
          $display("FAIL %s_byte%0d got d=%h last=%b lat=%0d want d=%h last=%b lat=3",
                   tag, i, d, l, cyc, 8'(i) ^ 8'h3C, (i == 127));
        bad++;
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL %s_bytes got %0d bad want 0", tag, bad);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done got pulses=%0d busy=%b want 1 0", tag, done_cnt - d0, busy);
    end
    e0 = err_cnt;
    a0 = ack_toggle;
    @(negedge clk);
    req_toggle = ~req_toggle;
    repeat (6) @(negedge clk);
    n_tests++;
    if (err_cnt - e0 != 1 || ack_toggle !== a0) begin
      n_fail++;
      $display("FAIL %s_extra_req got errs=%0d ack=%b want 1 %b",
               tag, err_cnt - e0, ack_toggle, a0);
    end
  endtask

  task automatic test_full_and_clamp;
    for (int i = 0; i < 128; i++) write_byte(7'(i), 8'(i) ^ 8'h3C);
    run_full(8'd128, "full128");
    run_full(8'd200, "clamp200");
  endtask

  task automatic test_abort;
    logic [7:0] exp_d [4];
    logic [7:0] d;
    logic l, a0;
    int cyc, d0;
    exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    for (int i = 0; i < 4; i++) write_byte(7'(i), exp_d[i]);
    d0 = done_cnt;
    pulse_start(8'd4);
    for (int i = 0; i < 2; i++) begin
      req_and_wait(d, l, cyc);
      n_tests++;
      if (d !== exp_d[i] || cyc != 3) begin
        n_fail++;
        $display("FAIL abort_pre_byte%0d got d=%h lat=%0d want %h 3", i, d, cyc, exp_d[i]);
      end
    end
    write_byte(7'd2, 8'hFF);
    a0 = ack_toggle;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_busy got %b want 0", busy);
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (done_cnt != d0 || ack_toggle !== a0) begin
      n_fail++;
      $display("FAIL abort_quiet got pulses=%0d ack=%b want 0 %b", done_cnt - d0, ack_toggle, a0);
    end
    pulse_start(8'd4);
    for (int i = 0; i < 4; i++) begin
      req_and_wait(d, l, cyc);
      n_tests++;
      if (d !== exp_d[i] || l !== (i == 3) || cyc != 3) begin
        n_fail++;
        $display("FAIL abort_next_byte%0d got d=%h last=%b lat=%0d want %h %b 3",
                 i, d, l, cyc, exp_d[i], (i == 3));
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_fetch;
    logic [7:0] d;
    logic l;
    int cyc;
    pulse_start(8'd4);
    @(negedge clk);
    req_toggle = ~req_toggle;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({byte_data, byte_last, ack_toggle, busy, frame_done, req_err} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_mid got %h want 0",
               {byte_data, byte_last, ack_toggle, busy, frame_done, req_err});
    end
    @(negedge clk);
    req_toggle = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    pulse_start(8'd4);
    req_and_wait(d, l, cyc);
    n_tests++;
    if (d !== 8'hA0 || ack_toggle !== 1'b1 || cyc != 3 || l !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_restart got d=%h ack=%b lat=%0d last=%b want A0 1 3 0",
               d, ack_toggle, cyc, l);
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    frame_len = '0; start = 1'b0; abort = 1'b0; req_toggle = 1'b0;
    test_reset();
    test_basic_frame();
    test_zero_len_idle_req();
    test_full_and_clamp();
    test_abort();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
